// File: rtl/usrp_tag_chip_mtx_sig.sv
// Swept-tone (mtx) plus hopped pilot generator: two phase accumulators feeding a sine/cosine ROM, summed to I/Q.
// Output lags the accumulators by 3 enabled cycles; out_tready low freezes all state and the pipeline.
module usrp_tag_chip_mtx_sig #(
  parameter int SIN_COS_WIDTH = 16,
  parameter int PHASE_WIDTH   = 24,
  parameter int NSYMB_WIDTH   = 16,
  parameter int NSIG          = 32768,
  parameter int NSYMB         = 512,
  parameter int DPH_INC       = 16384,
  parameter int START_PH_INC  = -4185088,
  parameter int PILOT_NHOP    = 64,
  parameter int PILOT_NSIG    = 262144,
  parameter int PILOT_DPH_INC = 131072,
  parameter int PILOT_SPH_INC = -4192256,
  parameter logic [PHASE_WIDTH-1:0] START_PH = '0,
  parameter int NLOC_PER_SYNC = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     srst,
  input  logic                     phase_tvalid,
  input  logic                     phase_tlast,
  input  logic                     out_tready,
  output logic                     sync_ready,
  output logic [SIN_COS_WIDTH-1:0] imtx,
  output logic [SIN_COS_WIDTH-1:0] qmtx,
  output logic [NSYMB_WIDTH-1:0]   mtx_symbN,
  output logic [NSYMB_WIDTH-1:0]   pilot_symbN,
  output logic [PHASE_WIDTH-1:0]   mtx_sigN,
  output logic [PHASE_WIDTH-1:0]   pilot_sigN,
  output logic [PHASE_WIDTH-1:0]   mtx_ph,
  output logic [PHASE_WIDTH-1:0]   pilot_ph
);
  localparam int W  = SIN_COS_WIDTH;
  localparam int PW = PHASE_WIDTH;
  localparam int SW = NSYMB_WIDTH;
  localparam longint AMP = (64'sd1 <<< (W - 3)) - 64'sd1;
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [SW-1:0] SONE = SW'(1);
  localparam logic [PW-1:0] SIG_LAST   = PW'(NSIG - 1);
  localparam logic [SW-1:0] SYMB_LAST  = SW'(NSYMB - 1);
  localparam logic [PW-1:0] PSIG_LAST  = PW'(PILOT_NSIG - 1);
  localparam logic [SW-1:0] PSYMB_LAST = SW'(PILOT_NHOP - 1);
  localparam logic [SW-1:0] LOC_LAST   = SW'(NLOC_PER_SYNC - 1);
  localparam logic [PW-1:0] MTX_INC0   = PW'(START_PH_INC);
  localparam logic [PW-1:0] MTX_DINC   = PW'(DPH_INC);
  localparam logic [PW-1:0] PIL_INC0   = PW'(PILOT_SPH_INC);
  localparam logic [PW-1:0] PIL_DINC   = PW'(PILOT_DPH_INC);

  // round(AMP*sin(pi*m/512)) for m in 0..256, via a Q30 Taylor series
  function automatic longint qsin(int m);
    longint x, term, sum, r;
    x = (longint'(m) * 64'sd3373259426 + 64'sd256) / 64'sd512;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    r = (sum * AMP + (64'sd1 <<< 29)) >>> 30;
    return (r > AMP) ? AMP : r;
  endfunction

  function automatic logic [257*W-1:0] gen_qtab();
    logic [257*W-1:0] t;
    t = '0;
    for (int m = 0; m <= 256; m++) t[m*W +: W] = W'(qsin(m));
    return t;
  endfunction

  localparam logic [257*W-1:0] QTAB = gen_qtab();

  // Full 1024-entry sine table reconstructed from the quarter wave by symmetry
  function automatic logic signed [W-1:0] tone_sin(logic [9:0] k);
    logic [8:0] j;
    logic signed [W-1:0] v;
    j = k[8] ? (9'd256 - {1'b0, k[7:0]}) : {1'b0, k[7:0]};
    v = QTAB[j*W +: W];
    return k[9] ? -v : v;
  endfunction

  function automatic logic [W-1:0] sat_add(logic signed [W-1:0] a, logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  logic rst_n;
  logic unused;
  assign unused = phase_tlast;

  // Assert asynchronously, release on the clock edge after reset goes high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_n <= 1'b0;
    else        rst_n <= 1'b1;
  end

  logic adv;
  assign adv = phase_tvalid & out_tready & ~sync_ready & ~srst;

  logic [PW-1:0] mtx_inc, pilot_inc;
  logic [SW-1:0] sweep_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || srst) begin
      mtx_ph     <= START_PH;
      mtx_inc    <= MTX_INC0;
      mtx_sigN   <= '0;
      mtx_symbN  <= '0;
      sweep_cnt  <= '0;
      sync_ready <= 1'b0;
    end else if (adv) begin
      mtx_ph <= mtx_ph + mtx_inc;
      if (mtx_sigN == SIG_LAST) begin
        mtx_sigN <= '0;
        if (mtx_symbN == SYMB_LAST) begin
          mtx_symbN <= '0;
          mtx_inc   <= MTX_INC0;
          sweep_cnt <= sweep_cnt + SONE;
          if (sweep_cnt == LOC_LAST) sync_ready <= 1'b1;
        end else begin
          mtx_symbN <= mtx_symbN + SONE;
          mtx_inc   <= mtx_inc + MTX_DINC;
        end
      end else begin
        mtx_sigN <= mtx_sigN + PONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || srst) begin
      pilot_ph    <= START_PH;
      pilot_inc   <= PIL_INC0;
      pilot_sigN  <= '0;
      pilot_symbN <= '0;
    end else if (adv) begin
      pilot_ph <= pilot_ph + pilot_inc;
      if (pilot_sigN == PSIG_LAST) begin
        pilot_sigN <= '0;
        if (pilot_symbN == PSYMB_LAST) begin
          pilot_symbN <= '0;
          pilot_inc   <= PIL_INC0;
        end else begin
          pilot_symbN <= pilot_symbN + SONE;
          pilot_inc   <= pilot_inc + PIL_DINC;
        end
      end else begin
        pilot_sigN <= pilot_sigN + PONE;
      end
    end
  end

  logic [9:0] a_mtx, a_pil;
  logic       a_zero;
  logic signed [W-1:0] c_mtx, s_mtx, c_pil, s_pil;

  // a_zero carries "sync reached" down the pipe so the tone sum settles at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || srst) begin
      a_mtx  <= '0;
      a_pil  <= '0;
      a_zero <= 1'b0;
      c_mtx  <= '0;
      s_mtx  <= '0;
      c_pil  <= '0;
      s_pil  <= '0;
      imtx   <= '0;
      qmtx   <= '0;
    end else if (out_tready) begin
      a_mtx  <= sync_ready ? 10'd0 : mtx_ph[PW-1 -: 10];
      a_pil  <= sync_ready ? 10'd0 : pilot_ph[PW-1 -: 10];
      a_zero <= sync_ready;
      c_mtx  <= a_zero ? '0 : tone_sin(a_mtx + 10'd256);
      s_mtx  <= a_zero ? '0 : tone_sin(a_mtx);
      c_pil  <= a_zero ? '0 : tone_sin(a_pil + 10'd256);
      s_pil  <= a_zero ? '0 : tone_sin(a_pil);
      imtx   <= sat_add(c_mtx, c_pil);
      qmtx   <= sat_add(s_mtx, s_pil);
    end
  end
endmodule

// File: tb/tb_usrp_tag_chip_mtx_sig.sv
// Directed bench: a small-parameter instance for counters/sync/hold/srst and a default instance for tone values and async reset.
module tb_usrp_tag_chip_mtx_sig;
  logic clk;
  int tests = 0;
  int fails = 0;

  logic        rst_s, srst_s, vld_s, rdy_s, last_s;
  logic        s_sync;
  logic [15:0] s_i, s_q, s_symb, s_psymb;
  logic [23:0] s_sig, s_psig, s_ph, s_pph;

  logic        rst_d, srst_d, vld_d, rdy_d, last_d;
  logic        d_sync;
  logic [15:0] d_i, d_q, d_symb, d_psymb;
  logic [23:0] d_sig, d_psig, d_ph, d_pph;

  int exp_ph[6]   = '{8, 16, 24, 32, 56, 80};
  int exp_sig[6]  = '{1, 2, 3, 0, 1, 2};
  int exp_symb[6] = '{0, 0, 0, 1, 1, 1};

  usrp_tag_chip_mtx_sig #(
    .SIN_COS_WIDTH(16), .PHASE_WIDTH(24), .NSYMB_WIDTH(16),
    .NSIG(4), .NSYMB(3), .DPH_INC(16), .START_PH_INC(8),
    .PILOT_NHOP(2), .PILOT_NSIG(8), .PILOT_DPH_INC(4), .PILOT_SPH_INC(2),
    .START_PH(24'h000000), .NLOC_PER_SYNC(2)
  ) u_small (
    .clk(clk), .reset(rst_s), .srst(srst_s), .phase_tvalid(vld_s), .phase_tlast(last_s),
    .out_tready(rdy_s), .sync_ready(s_sync), .imtx(s_i), .qmtx(s_q),
    .mtx_symbN(s_symb), .pilot_symbN(s_psymb), .mtx_sigN(s_sig), .pilot_sigN(s_psig),
    .mtx_ph(s_ph), .pilot_ph(s_pph)
  );

  usrp_tag_chip_mtx_sig u_dflt (
    .clk(clk), .reset(rst_d), .srst(srst_d), .phase_tvalid(vld_d), .phase_tlast(last_d),
    .out_tready(rdy_d), .sync_ready(d_sync), .imtx(d_i), .qmtx(d_q),
    .mtx_symbN(d_symb), .pilot_symbN(d_psymb), .mtx_sigN(d_sig), .pilot_sigN(d_psig),
    .mtx_ph(d_ph), .pilot_ph(d_pph)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_s = 0; srst_s = 0; vld_s = 0; rdy_s = 0; last_s = 0;
    rst_d = 0; srst_d = 0; vld_d = 1; rdy_d = 1; last_d = 0;
    tick();
    tick();
    chk("rst_ph", s_ph, 0);
    chk("rst_pph", s_pph, 0);
    chk("rst_sig", s_sig, 0);
    chk("rst_sync", s_sync, 0);
    chk("rst_i", s_i, 0);
    chk("rst_d_i", d_i, 0);

    // release: first edge only synchronizes, advancing starts on the second
    rst_s = 1; vld_s = 1; rdy_s = 1;
    tick();
    chk("sync_edge_ph", s_ph, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("seq_ph%0d", i), s_ph, exp_ph[i]);
      chk($sformatf("seq_sig%0d", i), s_sig, exp_sig[i]);
      chk($sformatf("seq_symb%0d", i), s_symb, exp_symb[i]);
    end

    rdy_s = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ph", s_ph, 80);
      chk("hold_sig", s_sig, 2);
      chk("hold_symb", s_symb, 1);
      chk("hold_pph", s_pph, 12);
      chk("hold_psig", s_psig, 6);
      chk("hold_i", s_i, 16382);
      chk("hold_q", s_q, 0);
    end
    rdy_s = 1;
    tick();
    chk("resume_ph", s_ph, 104);
    chk("resume_sig", s_sig, 3);
    chk("resume_pph", s_pph, 14);

    vld_s = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("novld_ph", s_ph, 104);
      chk("novld_pph", s_pph, 14);
      chk("novld_i", s_i, 16382);
    end

    srst_s = 1;
    tick();
    chk("srst_ph", s_ph, 0);
    chk("srst_sig", s_sig, 0);
    chk("srst_symb", s_symb, 0);
    chk("srst_pph", s_pph, 0);
    chk("srst_psig", s_psig, 0);
    chk("srst_i", s_i, 0);
    srst_s = 0; vld_s = 1;

    repeat (23) tick();
    chk("pre_sync", s_sync, 0);
    chk("pre_sync_ph", s_ph, 536);
    tick();
    chk("sync_up", s_sync, 1);
    chk("sync_ph", s_ph, 576);
    chk("sync_sig", s_sig, 0);
    chk("sync_symb", s_symb, 0);
    chk("sync_pph", s_pph, 80);
    chk("sync_psymb", s_psymb, 1);
    chk("sync_psig", s_psig, 0);
    tick();
    chk("frozen_ph", s_ph, 576);
    chk("frozen_pph", s_pph, 80);
    tick();
    chk("flush2_i", s_i, 16382);
    tick();
    chk("flush3_i", s_i, 0);
    chk("flush3_q", s_q, 0);
    chk("flush3_sync", s_sync, 1);

    srst_s = 1;
    tick();
    chk("srst_sync", s_sync, 0);
    chk("srst2_ph", s_ph, 0);
    chk("srst2_psymb", s_psymb, 0);
    srst_s = 0;
    tick();
    chk("restart_ph", s_ph, 8);
    chk("restart_pph", s_pph, 2);

    // default instance: negative start increments wrap to quadrant 3
    rst_d = 1;
    tick();
    chk("d_sync_edge_ph", d_ph, 0);
    tick();
    chk("d_adv1_ph", d_ph, 24'hC02400);
    chk("d_adv1_pph", d_pph, 24'hC00800);
    chk("d_adv1_sig", d_sig, 1);
    tick();
    tick();
    chk("d_tone0_i", d_i, 16382);
    chk("d_tone0_q", d_q, 0);
    tick();
    chk("d_tone1_i", d_i, 0);
    chk("d_tone1_q", d_q, 16'hC002);
    repeat (3) tick();
    #3 rst_d = 0;
    #1;
    chk("d_async_i", d_i, 0);
    chk("d_async_q", d_q, 0);
    chk("d_async_ph", d_ph, 0);
    chk("d_async_pph", d_pph, 0);
    chk("d_async_sig", d_sig, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
